// File: rtl/gaussian_3x3_stream.sv
// Streaming 3x3 Gaussian blur (kernel [1 2 1; 2 4 2; 1 2 1], rounded divide by 16) on a raster pixel stream.
// Two line buffers feed a column-shifting window; taps outside the image are zero.
module gaussian_3x3_stream #(
    parameter int IMG_W = 256,
    parameter int IMG_H = 256,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_pixel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_pixel,
    output logic             out_sof,
    output logic             out_eol,
    output logic             out_eof
);
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = $clog2(IMG_H + 2);
    localparam int AW = WIDTH + 4;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    typedef enum logic [1:0] {FILL, RUN, FLUSH} state_t;
    state_t state, next_state;

    logic [CW-1:0]         col_in, col_out;
    logic [RW-1:0]         row_in, row_out;
    logic [WIDTH-1:0]      lb1 [IMG_W];
    logic [WIDTH-1:0]      lb2 [IMG_W];
    logic [2:0][WIDTH-1:0] win_l, win_m, new_col;
    logic                  advance, emit, fill_done, last_in, last_out;
    logic [AW-1:0]         sum;

    // Vertical [1 2 1] over one window column, with border rows/columns forced to zero.
    function automatic logic [AW-1:0] col_sum(input logic [2:0][WIDTH-1:0] c,
                                              input logic keep, input logic keep_top,
                                              input logic keep_bot);
        logic [AW-1:0] top, ctr, bot;
        top = keep_top ? AW'(c[0]) : '0;
        ctr = AW'(c[1]);
        bot = keep_bot ? AW'(c[2]) : '0;
        return keep ? (top + (ctr << 1) + bot) : '0;
    endfunction

    function automatic logic [WIDTH-1:0] round_div16(input logic [AW-1:0] s);
        logic [AW-1:0] r;
        r = s + AW'(8);
        return r[AW-1:4];
    endfunction

    always_comb begin
        fill_done = (row_in == RW'(1)) && (col_in == '0);
        last_in   = (row_in == ROW_LAST) && (col_in == COL_LAST);
        last_out  = (row_out == ROW_LAST) && (col_out == COL_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= FILL;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            FILL:    if (advance && fill_done) next_state = RUN;
            RUN:     if (advance && last_in)   next_state = FLUSH;
            FLUSH:   if (advance && last_out)  next_state = FILL;
            default: next_state = FILL;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        advance  = 1'b0;
        emit     = 1'b0;
        if (!rst) begin
            if (state == FLUSH) begin
                advance = !out_valid || out_ready;
            end else begin
                in_ready = !out_valid || out_ready;
                advance  = in_valid && in_ready;
            end
            emit = advance && (state != FILL);
        end
    end

    // Window columns are (oldest, previous, incoming); the centre pixel sits one column and one row behind the input.
    always_comb begin
        new_col[0] = lb2[col_in];
        new_col[1] = lb1[col_in];
        new_col[2] = (state == FLUSH) ? '0 : in_pixel;
        sum = col_sum(win_l, col_out != '0, row_out != '0, row_out != ROW_LAST)
            + (col_sum(win_m, 1'b1, row_out != '0, row_out != ROW_LAST) << 1)
            + col_sum(new_col, col_out != COL_LAST, row_out != '0, row_out != ROW_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_in  <= '0;
            row_in  <= '0;
            col_out <= '0;
            row_out <= '0;
        end else if (advance) begin
            if (state == FLUSH && last_out) begin
                col_in  <= '0;
                row_in  <= '0;
                col_out <= '0;
                row_out <= '0;
            end else begin
                if (col_in == COL_LAST) begin
                    col_in <= '0;
                    row_in <= row_in + RW'(1);
                end else begin
                    col_in <= col_in + CW'(1);
                end
                if (emit) begin
                    if (col_out == COL_LAST) begin
                        col_out <= '0;
                        row_out <= row_out + RW'(1);
                    end else begin
                        col_out <= col_out + CW'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_l <= '0;
            win_m <= '0;
            for (int i = 0; i < IMG_W; i++) begin
                lb1[i] <= '0;
                lb2[i] <= '0;
            end
        end else if (advance) begin
            win_l       <= win_m;
            win_m       <= new_col;
            lb1[col_in] <= new_col[2];
            lb2[col_in] <= new_col[1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_pixel <= '0;
            out_sof   <= 1'b0;
            out_eol   <= 1'b0;
            out_eof   <= 1'b0;
        end else if (emit) begin
            out_valid <= 1'b1;
            out_pixel <= round_div16(sum);
            out_sof   <= (row_out == '0) && (col_out == '0);
            out_eol   <= (col_out == COL_LAST);
            out_eof   <= last_out;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_gaussian_3x3_stream.sv
// Bench for gaussian_3x3_stream: direct 2-D convolution model plus a per-beat scoreboard,
// with hand-computed pixel values pinned for uniform, impulse, ramp, back-to-back and reset cases.
module tb_gaussian_3x3_stream;
    localparam int W = 8;
    localparam int H = 8;
    localparam int N = W * H;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_pixel = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_pixel;
    logic       out_sof, out_eol, out_eof;

    typedef struct packed {
        logic [7:0] pix;
        logic       sof;
        logic       eol;
        logic       eof;
    } beat_t;

    beat_t      exp_q[$];
    int         n_checks = 0;
    int         n_pass = 0;
    int         out_idx = 0;
    logic [7:0] cap [0:2*N-1];
    logic [7:0] img [0:N-1];
    bit         bp = 1'b0;
    bit         rand_valid = 1'b0;
    bit         stall_prev = 1'b0;
    int         prev_vals = 0;

    gaussian_3x3_stream #(.IMG_W(W), .IMG_H(H), .WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
        .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel),
        .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic check(input string name, input int got, input int want);
        n_checks++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, want);
    endtask

    function automatic int gauss_at(input int r, input int c);
        int s = 0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                int rr = r + dr;
                int cc = c + dc;
                int wr = (dr == 0) ? 2 : 1;
                int wc = (dc == 0) ? 2 : 1;
                if (rr >= 0 && rr < H && cc >= 0 && cc < W) s += wr * wc * int'(img[rr*W + cc]);
            end
        end
        return (s + 8) / 16;
    endfunction

    task automatic push_frame();
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                beat_t b;
                b.pix = 8'(gauss_at(r, c));
                b.sof = (r == 0 && c == 0);
                b.eol = (c == W - 1);
                b.eof = (r == H - 1 && c == W - 1);
                exp_q.push_back(b);
            end
        end
    endtask

    task automatic send_frame(input int count);
        for (int i = 0; i < count; i++) begin
            bit acc = 1'b0;
            int guard = 0;
            in_pixel = img[i];
            while (!acc) begin
                in_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
                @(negedge clk);
                acc = in_valid && in_ready;
                @(posedge clk);
                #1;
                guard++;
                if (guard > 500) begin
                    $display("FAIL accept_timeout: pixel %0d not accepted after %0d cycles", i, guard);
                    $fatal(1, "input stuck");
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int guard = 0;
        while (exp_q.size() != 0 && guard < 2000) begin
            @(posedge clk);
            guard++;
        end
        check({name, "_pending"}, exp_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : cmp_proc
        beat_t e;
        if (rst) begin
            check("rst_out_valid", out_valid, 0);
            check("rst_flags", {out_sof, out_eol, out_eof}, 0);
            check("rst_out_pixel", out_pixel, 0);
            check("rst_in_ready", in_ready, 0);
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", {out_pixel, out_sof, out_eol, out_eof}, prev_vals);
            end
            if (out_valid && !out_ready) check("stall_in_ready", in_ready, 0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL extra_output: got pixel %0d with no output expected", out_pixel);
                end else begin
                    e = exp_q.pop_front();
                    check("pixel", out_pixel, e.pix);
                    check("flags", {out_sof, out_eol, out_eof}, {e.sof, e.eol, e.eof});
                end
                cap[out_idx % (2*N)] = out_pixel;
                out_idx++;
            end
            stall_prev = out_valid && !out_ready;
            prev_vals  = int'({out_pixel, out_sof, out_eol, out_eof});
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Uniform 100 frame, continuous flow
        for (int i = 0; i < N; i++) img[i] = 8'd100;
        out_idx = 0;
        push_frame();
        send_frame(N);
        for (int k = 0; k < W + 1; k++) begin
            @(negedge clk);
            check("flush_in_ready", in_ready, 0);
        end
        @(negedge clk);
        check("fill_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        drain("uniform");
        check("uni_corner", cap[0], 56);
        check("uni_top_edge", cap[1], 75);
        check("uni_left_edge", cap[W], 75);
        check("uni_interior", cap[W+1], 100);
        check("uni_last_corner", cap[N-1], 56);
        check("uni_count", out_idx, N);

        // Impulse at (5,5)
        for (int i = 0; i < N; i++) img[i] = 8'd0;
        img[5*W + 5] = 8'd255;
        out_idx = 0;
        push_frame();
        send_frame(N);
        drain("impulse");
        check("imp_centre", cap[5*W + 5], 64);
        check("imp_left", cap[5*W + 4], 32);
        check("imp_right", cap[5*W + 6], 32);
        check("imp_up", cap[4*W + 5], 32);
        check("imp_down", cap[6*W + 5], 32);
        check("imp_diag_ul", cap[4*W + 4], 16);
        check("imp_diag_dr", cap[6*W + 6], 16);
        check("imp_far", cap[5*W + 7], 0);
        check("imp_origin", cap[0], 0);

        // Ramp with random backpressure and random input valid
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) img[r*W + c] = 8'(r*16 + c*2);
        out_idx = 0;
        bp = 1'b1;
        rand_valid = 1'b1;
        push_frame();
        send_frame(N);
        drain("ramp_bp");
        bp = 1'b0;
        rand_valid = 1'b0;
        check("ramp_origin", cap[0], 3);
        check("ramp_interior", cap[W+1], 18);
        check("ramp_count", out_idx, N);

        // Back-to-back frames: all 200 then all 0
        for (int i = 0; i < N; i++) img[i] = 8'd200;
        out_idx = 0;
        push_frame();
        send_frame(N);
        for (int i = 0; i < N; i++) img[i] = 8'd0;
        push_frame();
        send_frame(N);
        drain("b2b");
        check("b2b_a_first", cap[0], 113);
        check("b2b_a_last", cap[N-1], 113);
        check("b2b_b_first", cap[N], 0);
        check("b2b_b_top_edge", cap[N+3], 0);
        check("b2b_b_last", cap[2*N-1], 0);
        check("b2b_count", out_idx, 2*N);

        // Reset mid-frame, then a clean uniform frame
        for (int i = 0; i < N; i++) img[i] = 8'd100;
        out_idx = 0;
        push_frame();
        send_frame(40);
        repeat (3) @(posedge clk);
        #1;
        check("partial_outputs", out_idx, 40 - (W + 1));
        rst = 1'b1;
        repeat (3) @(posedge clk);
        exp_q.delete();
        #1;
        rst = 1'b0;
        out_idx = 0;
        push_frame();
        send_frame(N);
        drain("after_reset");
        check("rst_frame_corner", cap[0], 56);
        check("rst_frame_edge", cap[1], 75);
        check("rst_frame_interior", cap[W+1], 100);
        check("rst_frame_count", out_idx, N);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
